// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter that shares one main-memory port between
//               two cache controllers. It captures strobe requests, holds the
//               memory strobe for MEM_WAIT cycles and returns read data with
//               a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_strobe,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_rdy,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_strobe,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_rdy,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_strobe,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int c_CNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             pending_q, pending_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]             hold_rw_q, hold_rw_d;
    logic [1:0][AW-1:0]     hold_addr_q, hold_addr_d;
    logic [1:0][DW-1:0]     hold_wdata_q, hold_wdata_d;
    logic                   mem_strobe_q, mem_strobe_d;
    logic                   mem_rw_q, mem_rw_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
    logic [1:0]             rdy_q, rdy_d;
    logic [1:0][DW-1:0]     rdata_q, rdata_d;
    logic                   busy_q, busy_d;

    // Requester inputs gathered into vectors so both ports share one code path.
    logic [1:0]             w_strobe;
    logic [1:0]             w_rw;
    logic [1:0][AW-1:0]     w_addr;
    logic [1:0][DW-1:0]     w_wdata;
    logic [1:0]             w_accept;
    logic                   w_sel;

    assign w_strobe = {req1_strobe, req0_strobe};
    assign w_rw     = {req1_rw, req0_rw};
    assign w_addr   = {req1_addr, req0_addr};
    assign w_wdata  = {req1_wdata, req0_wdata};

    // A strobe is dropped while that requester already waits or is being served.
    assign w_accept[0] = w_strobe[0] && !pending_q[0] &&
                         !(state_q == S_ACCESS && grant_q == 1'b0);
    assign w_accept[1] = w_strobe[1] && !pending_q[1] &&
                         !(state_q == S_ACCESS && grant_q == 1'b1);

    // Next-state logic: arbitration, access timing, completion and capture.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        hold_rw_d    = hold_rw_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        mem_strobe_d = mem_strobe_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdy_d        = 2'b00;
        rdata_d      = rdata_q;
        w_sel        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != 2'b00) begin
                    // On a tie the requester not served last time wins.
                    w_sel = (&pending_q) ? ~last_grant_q : pending_q[1];
                    grant_d          = w_sel;
                    pending_d[w_sel] = 1'b0;
                    mem_rw_d         = hold_rw_q[w_sel];
                    mem_addr_d       = hold_addr_q[w_sel];
                    mem_wdata_d      = hold_wdata_q[w_sel];
                    mem_strobe_d     = 1'b1;
                    cnt_d            = c_CNT_W'(MEM_WAIT - 1);
                    state_d          = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end else begin
                    if (!mem_rw_q) begin
                        rdata_d[grant_q] = mem_rdata;
                    end
                    mem_strobe_d   = 1'b0;
                    rdy_d[grant_q] = 1'b1;
                    last_grant_d   = grant_q;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int n = 0; n < 2; n++) begin
            if (w_accept[n]) begin
                pending_d[n]    = 1'b1;
                hold_rw_d[n]    = w_rw[n];
                hold_addr_d[n]  = w_addr[n];
                hold_wdata_d[n] = w_wdata[n];
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= 2'b00;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            hold_rw_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            mem_strobe_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdy_q        <= 2'b00;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            hold_rw_q    <= hold_rw_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            mem_strobe_q <= mem_strobe_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdy_q        <= rdy_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_strobe = mem_strobe_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign req0_rdy   = rdy_q[0];
    assign req1_rdy   = rdy_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign busy       = busy_q;

endmodule
`default_nettype wire
